cursor_controller: RTL
======================

# cursor_controller

Keypad controller for the 6x6 VGA grid cursor. It synchronizes, debounces and arbitrates the four arrow keys and a select key, then produces at most one action per debounced press: either a move with row/column clamping or a select pulse. Holding a single arrow key generates auto-repeat moves. The block drives the cursor index consumed by the VGA renderer and the board logic.

## Interface
- GRID_COLS, 6, cells per row
- GRID_ROWS, 6, rows; cursor range 0..GRID_COLS*GRID_ROWS-1
- DEBOUNCE_CYCLES, 500000, stable cycles required to accept a press or a release
- REPEAT_DELAY, 25000000, hold cycles from the first move to the first repeat
- REPEAT_RATE, 5000000, cycles between subsequent repeats
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; returns the block to reset state immediately
- keys  in  4  raw, asynchronous, active-high; [0] up, [1] down, [2] left, [3] right
- sel  in  1  raw, asynchronous, active-high select key
- cursor  out  6  current cell index, row-major; reset 0
- move_strobe  out  1  one-cycle pulse, asserted only when cursor changed this cycle; reset 0
- select_strobe  out  1  one-cycle pulse on an accepted select; reset 0
- key_active  out  1  high in any state other than IDLE; reset 0

## Operation
- Each of the 5 raw inputs passes through a 2-FF synchronizer. The synchronized 5-bit vector is called req, bit 4 = sel.
- FSM states: IDLE, DEBOUNCE, ACT, HOLD, WAIT_RELEASE.
- IDLE: on req != 0, latch req into lat, clear cnt, go to DEBOUNCE.
- DEBOUNCE:
  - req == lat: increment cnt.
  - req differs and is nonzero: relatch lat, cnt=1.
  - req == 0: go to IDLE.
  - cnt reaching DEBOUNCE_CYCLES: go to ACT.
- ACT (exactly 1 cycle): arbitrate lat with fixed priority sel > up > down > left > right.
  - Grant sel: select_strobe=1.
  - Grant arrow: cursor <= step(cursor, dir).
  - Both cases then go to HOLD if lat has exactly one bit set and it is an arrow; otherwise go to WAIT_RELEASE.
- step() clamps and never wraps:
  - up at row 0, down at last row, left at col 0, right at col GRID_COLS-1: no change and no move_strobe.
  - Otherwise ±1 for left/right, ±GRID_COLS for up/down.
- HOLD: cnt counts cycles since ACT.
  - When cnt reaches REPEAT_DELAY for the first repeat, or REPEAT_RATE for later ones: re-enter ACT and restart cnt.
  - req != lat: go to WAIT_RELEASE.
- WAIT_RELEASE: no actions. req must be 0 for DEBOUNCE_CYCLES consecutive cycles before going to IDLE; any nonzero sample restarts the count.
- Counter width is $clog2(max of the three timing params + 1), unsigned. Compare with ==; there is no overflow path.

## Timing
- Input-to-action latency: the strobe and the new cursor value appear DEBOUNCE_CYCLES+3 clocks after a clean input edge (2 sync + DEBOUNCE_CYCLES + ACT). Cursor and move_strobe change on the same edge.
- Strobes are registered, high for exactly one cycle, and never both high at once.
- Repeat moves start REPEAT_DELAY cycles after the first ACT, then occur every REPEAT_RATE cycles.
- Reset mid-operation: all outputs return to reset values asynchronously and the FSM goes to IDLE. A key still held after reset deasserts counts as a new press.
- Minimum key-release-to-next-press gap is DEBOUNCE_CYCLES.

## Structure
- Package cursor_pkg holds:
  - state enum (state_t)
  - direction enum (dir_t: UP, DOWN, LEFT, RIGHT)
  - GRID_COLS/GRID_ROWS defaults
  - key bit-index constants
- Sub-module cursor_step: combinational (cursor, dir) -> (next, moved) clamping logic, parameterized by grid size. It is reusable by the board logic.
- Top: synchronizers, FSM, counter and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
- Reset then right held for 10 cycles, then released -> cursor 0→1 at cycle 7 after press; one move_strobe; key_active falls 4+2 cycles after release.
- Cursor=0: press up and left separately -> cursor stays 0, no move_strobe; key_active still cycles normally.
- Cursor=5: press right -> stays 5 (no row wrap). Cursor=30: press down -> stays 30.
- Hold down from cursor=0 for 60 cycles -> moves at cycles 7, 27, 35, 43, 51 reaching 30 then clamped; strobes only on the 5 real moves (0→6→12→18→24→30).
- sel+left pressed together -> single select_strobe, cursor unchanged, no repeat; WAIT_RELEASE until both released.
- 2-cycle glitch on up, and reset asserted mid-HOLD -> no action on glitch; reset forces cursor=0 and strobes=0 on the same cycle.

Source files
------------

// File: rtl/cursor_pkg.sv
`default_nettype none
// ============================================================================
// cursor_pkg: shared types and constants for the keypad cursor controller.
// Revision 1.0
// ============================================================================
package cursor_pkg;

    localparam int GRID_COLS_DEF = 6;
    localparam int GRID_ROWS_DEF = 6;

    // Bit positions inside the synchronized request vector
    localparam int NUM_KEYS  = 5;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_SEL   = 4;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DEBOUNCE     = 3'd1,
        ACT          = 3'd2,
        HOLD         = 3'd3,
        WAIT_RELEASE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Auto-repeat only applies when exactly one arrow and no select is latched
    function automatic logic is_single_arrow(input logic [NUM_KEYS-1:0] lat);
        logic [3:0] arrows;
        arrows = lat[KEY_RIGHT:KEY_UP];
        return !lat[KEY_SEL] && (arrows != 4'd0) && ((arrows & (arrows - 4'd1)) == 4'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_step.sv
`default_nettype none
// ============================================================================
// cursor_step: one clamped cursor step on a row-major grid (never wraps).
// Revision 1.0
// ============================================================================
module cursor_step
    import cursor_pkg::*;
#(
    parameter int GRID_COLS = GRID_COLS_DEF,
    parameter int GRID_ROWS = GRID_ROWS_DEF,
    parameter int CURSOR_W  = $clog2(GRID_COLS * GRID_ROWS)
) (
    input  logic [CURSOR_W-1:0] cursor_i,
    input  dir_t                dir_i,
    output logic [CURSOR_W-1:0] next_o,
    output logic                moved_o
);

    localparam logic [CURSOR_W-1:0] COLS_W        = CURSOR_W'(GRID_COLS);
    localparam logic [CURSOR_W-1:0] LAST_COL      = CURSOR_W'(GRID_COLS - 1);
    localparam logic [CURSOR_W-1:0] LAST_ROW_BASE = CURSOR_W'(GRID_COLS * (GRID_ROWS - 1));

    logic [CURSOR_W-1:0] w_col;

    assign w_col = cursor_i % COLS_W;

    always_comb begin
        next_o  = cursor_i;
        moved_o = 1'b0;
        case (dir_i)
            UP: begin
                if (cursor_i >= COLS_W) begin
                    next_o  = cursor_i - COLS_W;
                    moved_o = 1'b1;
                end
            end
            DOWN: begin
                if (cursor_i < LAST_ROW_BASE) begin
                    next_o  = cursor_i + COLS_W;
                    moved_o = 1'b1;
                end
            end
            LEFT: begin
                if (w_col != '0) begin
                    next_o  = cursor_i - CURSOR_W'(1);
                    moved_o = 1'b1;
                end
            end
            RIGHT: begin
                if (w_col != LAST_COL) begin
                    next_o  = cursor_i + CURSOR_W'(1);
                    moved_o = 1'b1;
                end
            end
            default: begin
                next_o  = cursor_i;
                moved_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cursor_controller.sv
`default_nettype none
// ============================================================================
// cursor_controller: synchronizes, debounces and arbitrates keypad presses
// into clamped cursor moves (with auto-repeat) or select pulses. Revision 1.0
// ============================================================================
module cursor_controller
    import cursor_pkg::*;
#(
    parameter int GRID_COLS       = GRID_COLS_DEF,
    parameter int GRID_ROWS       = GRID_ROWS_DEF,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [3:0]                             keys_i,
    input  logic                                   sel_i,
    output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0] cursor_o,
    output logic                                   move_strobe_o,
    output logic                                   select_strobe_o,
    output logic                                   key_active_o
);

    localparam int CURSOR_W = $clog2(GRID_COLS * GRID_ROWS);
    localparam int CNT_W    = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);

    // The sample that enters a counting state is itself the first counted
    // sample, so the terminal compares sit one below the nominal period.
    // Timing parameters are expected to be at least 3.
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_FULL   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] req_q;
    logic [NUM_KEYS-1:0] lat_q;
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                repeat_q;
    logic [CURSOR_W-1:0] cursor_q;
    logic                move_strobe_q;
    logic                select_strobe_q;
    logic                key_active_q;

    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    w_hold_last;
    logic                w_act_sel;
    dir_t                w_act_dir;
    logic [CURSOR_W-1:0] w_step_next;
    logic                w_step_moved;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            req_q   <= '0;
        end else begin
            sync1_q <= {sel_i, keys_i};
            req_q   <= sync1_q;
        end
    end

    assign w_cnt_inc   = cnt_q + CNT_W'(1);
    assign w_hold_last = repeat_q ? RATE_LAST : DELAY_LAST;

    // Fixed priority: sel > up > down > left > right
    always_comb begin
        w_act_sel = lat_q[KEY_SEL];
        w_act_dir = RIGHT;
        if (lat_q[KEY_UP]) begin
            w_act_dir = UP;
        end else if (lat_q[KEY_DOWN]) begin
            w_act_dir = DOWN;
        end else if (lat_q[KEY_LEFT]) begin
            w_act_dir = LEFT;
        end
    end

    cursor_step #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS),
        .CURSOR_W  (CURSOR_W)
    ) u_step (
        .cursor_i (cursor_q),
        .dir_i    (w_act_dir),
        .next_o   (w_step_next),
        .moved_o  (w_step_moved)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            lat_q           <= '0;
            cnt_q           <= '0;
            repeat_q        <= 1'b0;
            cursor_q        <= '0;
            move_strobe_q   <= 1'b0;
            select_strobe_q <= 1'b0;
            key_active_q    <= 1'b0;
        end else begin
            move_strobe_q   <= 1'b0;
            select_strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_q != '0) begin
                        lat_q        <= req_q;
                        cnt_q        <= '0;
                        state_q      <= DEBOUNCE;
                        key_active_q <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (req_q == '0) begin
                        state_q      <= IDLE;
                        key_active_q <= 1'b0;
                    end else if (req_q != lat_q) begin
                        lat_q <= req_q;
                        cnt_q <= CNT_W'(1);
                    end else if (w_cnt_inc == DEB_LAST) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b0;
                        state_q  <= ACT;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                ACT: begin
                    if (w_act_sel) begin
                        select_strobe_q <= 1'b1;
                    end else begin
                        cursor_q      <= w_step_next;
                        move_strobe_q <= w_step_moved;
                    end
                    cnt_q   <= '0;
                    state_q <= is_single_arrow(lat_q) ? HOLD : WAIT_RELEASE;
                end
                HOLD: begin
                    if (req_q != lat_q) begin
                        // A released sample here already counts toward release
                        cnt_q   <= (req_q == '0) ? CNT_W'(1) : '0;
                        state_q <= WAIT_RELEASE;
                    end else if (w_cnt_inc == w_hold_last) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                        state_q  <= ACT;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                WAIT_RELEASE: begin
                    if (req_q != '0) begin
                        cnt_q <= '0;
                    end else if (w_cnt_inc == DEB_FULL) begin
                        cnt_q        <= '0;
                        state_q      <= IDLE;
                        key_active_q <= 1'b0;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    key_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign cursor_o        = cursor_q;
    assign move_strobe_o   = move_strobe_q;
    assign select_strobe_o = select_strobe_q;
    assign key_active_o    = key_active_q;

endmodule
`default_nettype wire
